// File: rtl/afb_ctrl_pkg.sv
// Shared types and constants for the AFB run controller: FSM state encoding,
// sticky-status bit positions, fatal-flag mask and error-counter geometry.
package afb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_RUN       = 3'd2,
    ST_DRAIN_IN  = 3'd3,
    ST_DRAIN_OUT = 3'd4,
    ST_HALT      = 3'd5
  } afb_state_e;

  localparam int unsigned STAT_PPF_SAT     = 0;
  localparam int unsigned STAT_REORDER_OVF = 1;
  localparam int unsigned STAT_FFT_UNF     = 2;
  localparam int unsigned STAT_FFT_OVF     = 3;
  localparam int unsigned STAT_FFT_SAT     = 4;
  localparam int unsigned STAT_DRAIN_TMO   = 5;
  localparam int unsigned STAT_W           = 6;

  // Reorder overflow, FFT underflow and FFT overflow are fatal.
  localparam logic [STAT_W-1:0] FATAL_MASK = 6'b001110;

  localparam int unsigned ERR_CNT_N = 4;
  localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/afb_frame_counter.sv
// Sample index modulo 2^IDX_W plus a frame counter bumped on each index wrap.
module afb_frame_counter #(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_index,
  output logic [CNT_W-1:0] o_frames
);

  logic [IDX_W-1:0] idx_d, idx_q;
  logic [CNT_W-1:0] frames_d, frames_q;
  logic             wrap;

  always_comb begin
    wrap     = i_inc && (idx_q == '1);
    idx_d    = idx_q;
    frames_d = frames_q;
    if (i_clear) begin
      idx_d    = '0;
      frames_d = '0;
    end else if (i_inc) begin
      idx_d = idx_q + 1'b1;
      if (wrap) frames_d = frames_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      idx_q    <= '0;
      frames_q <= '0;
    end else begin
      idx_q    <= idx_d;
      frames_q <= frames_d;
    end
  end

  assign o_index  = idx_q;
  assign o_frames = frames_q;

endmodule

// File: rtl/afb_ctrl.sv
// AFB run controller: paced sample gating, per-run config latch, frame-aligned
// drain, sticky error status. AFB_CTRL_ERR_CNT_EN adds per-flag error counters.
module afb_ctrl
  import afb_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned LOG2LEN       = 10,
  parameter int unsigned FRAME_CNT_W   = 16,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_clear_status,
  input  logic [3:0]             i_cfg_gain_pow2,
  input  logic [2*LOG2LEN-1:0]   i_cfg_fft_rounding,
  input  logic                   i_cfg_halt_on_err,
  input  logic [WIDTH-1:0]       i_in_inph,
  input  logic [WIDTH-1:0]       i_in_quad,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic [WIDTH-1:0]       o_afb_inph,
  output logic [WIDTH-1:0]       o_afb_quad,
  output logic                   o_afb_valid,
  output logic                   o_afb_enable,
  output logic [3:0]             o_afb_gain_pow2,
  output logic [2*LOG2LEN-1:0]   o_afb_fft_rounding,
  input  logic                   i_afb_out_valid,
  input  logic                   i_afb_out_ready,
  input  logic                   i_afb_ppf_saturate,
  input  logic                   i_afb_reorder_overflow,
  input  logic                   i_afb_fft_underflow,
  input  logic                   i_afb_fft_overflow,
  input  logic [LOG2LEN-1:0]     i_afb_fft_saturate,
  output logic [2:0]             o_state,
  output logic                   o_busy,
  output logic [FRAME_CNT_W-1:0] o_in_frames,
  output logic [FRAME_CNT_W-1:0] o_out_frames,
  output logic [STAT_W-1:0]      o_status
`ifdef AFB_CTRL_ERR_CNT_EN
  ,
  output logic [ERR_CNT_N-1:0][ERR_CNT_W-1:0] o_err_cnt
`endif
);

  localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  afb_state_e             state_d, state_q;
  logic                   enable_d, enable_q;
  logic                   valid_d, valid_q;
  logic                   gap_d, gap_q;
  logic [WIDTH-1:0]       inph_d, inph_q, quad_d, quad_q;
  logic [3:0]             gain_d, gain_q;
  logic [2*LOG2LEN-1:0]   round_d, round_q;
  logic                   hoe_d, hoe_q;
  logic [STAT_W-1:0]      status_d, status_q;
  logic [TMO_W-1:0]       tmo_d, tmo_q;

  logic [STAT_W-1:0]      flags;
  logic                   fatal, active, in_ready, xfer, out_hs, start_go, tmo_set;
  logic [LOG2LEN-1:0]     in_idx, out_idx_unused;
  logic [FRAME_CNT_W-1:0] in_frames, out_frames;

  always_comb begin
    flags    = {1'b0, |i_afb_fft_saturate, i_afb_fft_overflow, i_afb_fft_underflow,
                i_afb_reorder_overflow, i_afb_ppf_saturate};
    fatal    = |(flags & FATAL_MASK);
    active   = state_q inside {ST_START, ST_RUN, ST_DRAIN_IN, ST_DRAIN_OUT};
    // Draining stops accepting once the input sits on a frame boundary.
    in_ready = !gap_q && ((state_q == ST_RUN) ||
                          ((state_q == ST_DRAIN_IN) && (in_idx != '0)));
    xfer     = i_in_valid && in_ready;
    out_hs   = i_afb_out_valid && i_afb_out_ready && (state_q != ST_IDLE);
    start_go = (state_q == ST_IDLE) && i_start;
  end

  afb_frame_counter #(.IDX_W(LOG2LEN), .CNT_W(FRAME_CNT_W)) u_in_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (start_go),
    .i_inc   (xfer),
    .o_index (in_idx),
    .o_frames(in_frames)
  );

  afb_frame_counter #(.IDX_W(LOG2LEN), .CNT_W(FRAME_CNT_W)) u_out_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (start_go),
    .i_inc   (out_hs),
    .o_index (out_idx_unused),
    .o_frames(out_frames)
  );

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    round_d = round_q;
    hoe_d   = hoe_q;
    tmo_d   = '0;
    tmo_set = 1'b0;
    if (active && hoe_q && fatal) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_IDLE: if (i_start) begin
          gain_d  = i_cfg_gain_pow2;
          round_d = i_cfg_fft_rounding;
          hoe_d   = i_cfg_halt_on_err;
          state_d = ST_START;
        end
        ST_START:    state_d = ST_RUN;
        ST_RUN:      if (i_stop) state_d = ST_DRAIN_IN;
        ST_DRAIN_IN: if (in_idx == '0) state_d = ST_DRAIN_OUT;
        ST_DRAIN_OUT: begin
          if (out_frames == in_frames) begin
            state_d = ST_IDLE;
          end else if (tmo_q == TMO_W'(DRAIN_TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            tmo_set = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_HALT:     if (i_stop || i_clear_status) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end

    enable_d = state_d inside {ST_START, ST_RUN, ST_DRAIN_IN, ST_DRAIN_OUT};
    valid_d  = xfer && (state_d != ST_HALT);
    gap_d    = xfer;
    inph_d   = xfer ? i_in_inph : inph_q;
    quad_d   = xfer ? i_in_quad : quad_q;

    status_d = i_clear_status ? '0 : status_q;
    if (enable_q) status_d = status_d | flags;
    if (tmo_set) status_d[STAT_DRAIN_TMO] = 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      valid_q  <= 1'b0;
      gap_q    <= 1'b0;
      inph_q   <= '0;
      quad_q   <= '0;
      gain_q   <= '0;
      round_q  <= '0;
      hoe_q    <= 1'b0;
      status_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      valid_q  <= valid_d;
      gap_q    <= gap_d;
      inph_q   <= inph_d;
      quad_q   <= quad_d;
      gain_q   <= gain_d;
      round_q  <= round_d;
      hoe_q    <= hoe_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef AFB_CTRL_ERR_CNT_EN
  logic [ERR_CNT_N-1:0][ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

  // Counter i tracks status bit i (ppf_sat, reorder_ovf, fft_unf, fft_ovf).
  always_comb begin
    for (int unsigned i = 0; i < ERR_CNT_N; i++) begin
      if (enable_q && flags[i])
        err_cnt_d[i] = (err_cnt_q[i] == '1) ? err_cnt_q[i] : err_cnt_q[i] + 1'b1;
      else if (i_clear_status)
        err_cnt_d[i] = '0;
      else
        err_cnt_d[i] = err_cnt_q[i];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt = err_cnt_q;
`endif

  assign o_in_ready         = in_ready;
  assign o_afb_inph         = inph_q;
  assign o_afb_quad         = quad_q;
  assign o_afb_valid        = valid_q;
  assign o_afb_enable       = enable_q;
  assign o_afb_gain_pow2    = gain_q;
  assign o_afb_fft_rounding = round_q;
  assign o_state            = state_q;
  assign o_busy             = (state_q != ST_IDLE);
  assign o_in_frames        = in_frames;
  assign o_out_frames       = out_frames;
  assign o_status           = status_q;

endmodule

// File: tb/tb_afb_ctrl.sv
// Randomized self-checking bench for afb_ctrl against a transaction-count model.
module tb_afb_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned L2L   = 4;
  localparam int unsigned FCW   = 16;
  localparam int unsigned DTMO  = 64;
  localparam int unsigned FRAME = 1 << L2L;

  logic             i_clock, i_reset;
  logic             i_start, i_stop, i_clear_status;
  logic [3:0]       i_cfg_gain_pow2;
  logic [2*L2L-1:0] i_cfg_fft_rounding;
  logic             i_cfg_halt_on_err;
  logic [WIDTH-1:0] i_in_inph, i_in_quad;
  logic             i_in_valid, o_in_ready;
  logic [WIDTH-1:0] o_afb_inph, o_afb_quad;
  logic             o_afb_valid, o_afb_enable;
  logic [3:0]       o_afb_gain_pow2;
  logic [2*L2L-1:0] o_afb_fft_rounding;
  logic             i_afb_out_valid, i_afb_out_ready;
  logic             i_afb_ppf_saturate, i_afb_reorder_overflow;
  logic             i_afb_fft_underflow, i_afb_fft_overflow;
  logic [L2L-1:0]   i_afb_fft_saturate;
  logic [2:0]       o_state;
  logic             o_busy;
  logic [FCW-1:0]   o_in_frames, o_out_frames;
  logic [5:0]       o_status;
`ifdef AFB_CTRL_ERR_CNT_EN
  logic [3:0][15:0] o_err_cnt;
`endif

  afb_ctrl #(.WIDTH(WIDTH), .LOG2LEN(L2L), .FRAME_CNT_W(FCW), .DRAIN_TIMEOUT(DTMO)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_clear_status(i_clear_status), .i_cfg_gain_pow2(i_cfg_gain_pow2),
    .i_cfg_fft_rounding(i_cfg_fft_rounding), .i_cfg_halt_on_err(i_cfg_halt_on_err),
    .i_in_inph(i_in_inph), .i_in_quad(i_in_quad), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .o_afb_inph(o_afb_inph), .o_afb_quad(o_afb_quad),
    .o_afb_valid(o_afb_valid), .o_afb_enable(o_afb_enable),
    .o_afb_gain_pow2(o_afb_gain_pow2), .o_afb_fft_rounding(o_afb_fft_rounding),
    .i_afb_out_valid(i_afb_out_valid), .i_afb_out_ready(i_afb_out_ready),
    .i_afb_ppf_saturate(i_afb_ppf_saturate), .i_afb_reorder_overflow(i_afb_reorder_overflow),
    .i_afb_fft_underflow(i_afb_fft_underflow), .i_afb_fft_overflow(i_afb_fft_overflow),
    .i_afb_fft_saturate(i_afb_fft_saturate), .o_state(o_state), .o_busy(o_busy),
    .o_in_frames(o_in_frames), .o_out_frames(o_out_frames), .o_status(o_status)
`ifdef AFB_CTRL_ERR_CNT_EN
    , .o_err_cnt(o_err_cnt)
`endif
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: run totals instead of index/frame registers.
  int          m_state;
  bit          m_gap, m_en, m_valid, m_hoe;
  int unsigned m_in_tot, m_out_tot, m_tmo;
  logic [5:0]  m_status;
  logic [3:0]  m_gain;
  logic [2*L2L-1:0] m_round;
  logic [WIDTH-1:0] m_di, m_dq;
  int unsigned m_err[4];

  // Stimulus knobs (percent, flags in permille).
  int unsigned vp, op, wild, fpm, sp, stp, clp;

  function automatic int unsigned frames_of(input int unsigned tot);
    return (tot / FRAME) % (1 << FCW);
  endfunction

  function automatic bit exp_ready();
    return !m_gap && ((m_state == 2) || (m_state == 3 && (m_in_tot % FRAME) != 0));
  endfunction

  task automatic model_reset();
    m_state = 0; m_gap = 0; m_en = 0; m_valid = 0; m_hoe = 0;
    m_in_tot = 0; m_out_tot = 0; m_tmo = 0; m_status = '0;
    m_gain = '0; m_round = '0; m_di = '0; m_dq = '0;
    for (int i = 0; i < 4; i++) m_err[i] = 0;
  endtask

  task automatic model_step();
    int ns;
    bit xfer, hs, fatal, active;
    bit fl[4];
    logic [5:0] st;
    active = (m_state >= 1 && m_state <= 4);
    xfer   = i_in_valid && exp_ready();
    hs     = i_afb_out_valid && i_afb_out_ready && (m_state != 0);
    fatal  = i_afb_reorder_overflow || i_afb_fft_underflow || i_afb_fft_overflow;
    fl[0] = i_afb_ppf_saturate; fl[1] = i_afb_reorder_overflow;
    fl[2] = i_afb_fft_underflow; fl[3] = i_afb_fft_overflow;
    st = i_clear_status ? 6'd0 : m_status;
    if (m_en) begin
      for (int i = 0; i < 4; i++) if (fl[i]) st[i] = 1'b1;
      if (i_afb_fft_saturate != 0) st[4] = 1'b1;
    end
    ns = m_state;
    if (active && m_hoe && fatal) ns = 5;
    else case (m_state)
      0: if (i_start) begin
        ns = 1; m_gain = i_cfg_gain_pow2; m_round = i_cfg_fft_rounding;
        m_hoe = i_cfg_halt_on_err; m_in_tot = 0; m_out_tot = 0;
      end
      1: ns = 2;
      2: if (i_stop) ns = 3;
      3: if (m_in_tot % FRAME == 0) ns = 4;
      4: if (frames_of(m_out_tot) == frames_of(m_in_tot)) ns = 0;
         else if (m_tmo == DTMO - 1) begin ns = 0; st[5] = 1'b1; end
      5: if (i_stop || i_clear_status) ns = 0;
      default: ns = 0;
    endcase
    m_tmo = (m_state == 4 && ns == 4) ? m_tmo + 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (m_en && fl[i]) m_err[i] = (m_err[i] == 65535) ? 65535 : m_err[i] + 1;
      else if (i_clear_status) m_err[i] = 0;
    end
    if (xfer) begin m_di = i_in_inph; m_dq = i_in_quad; m_in_tot++; end
    if (hs) m_out_tot++;
    m_valid  = xfer && (ns != 5);
    m_gap    = xfer;
    m_en     = (ns >= 1 && ns <= 4);
    m_status = st;
    m_state  = ns;
  endtask

  task automatic compare();
    check("state", o_state, m_state);
    check("busy", o_busy, m_state != 0);
    check("in_ready", o_in_ready, exp_ready());
    check("afb_valid", o_afb_valid, m_valid);
    check("afb_enable", o_afb_enable, m_en);
    check("afb_inph", o_afb_inph, m_di);
    check("afb_quad", o_afb_quad, m_dq);
    check("gain", o_afb_gain_pow2, m_gain);
    check("rounding", o_afb_fft_rounding, m_round);
    check("in_frames", o_in_frames, frames_of(m_in_tot));
    check("out_frames", o_out_frames, frames_of(m_out_tot));
    check("status", o_status, m_status);
`ifdef AFB_CTRL_ERR_CNT_EN
    for (int i = 0; i < 4; i++) check("err_cnt", o_err_cnt[i], m_err[i]);
`endif
  endtask

  task automatic rand_inputs();
    i_in_valid         = ($urandom_range(99) < vp);
    i_in_inph          = WIDTH'($urandom);
    i_in_quad          = WIDTH'($urandom);
    i_afb_out_ready    = ($urandom_range(99) < op);
    i_afb_out_valid    = ($urandom_range(99) < op) &&
                         ((m_out_tot < m_in_tot) || ($urandom_range(99) < wild));
    i_afb_ppf_saturate     = ($urandom_range(999) < fpm);
    i_afb_reorder_overflow = ($urandom_range(999) < fpm);
    i_afb_fft_underflow    = ($urandom_range(999) < fpm);
    i_afb_fft_overflow     = ($urandom_range(999) < fpm);
    i_afb_fft_saturate     = ($urandom_range(999) < fpm) ? L2L'(1 << $urandom_range(L2L-1)) : '0;
    i_start            = ($urandom_range(99) < sp);
    i_stop             = ($urandom_range(99) < stp);
    i_clear_status     = ($urandom_range(99) < clp);
    i_cfg_gain_pow2    = 4'($urandom);
    i_cfg_fft_rounding = (2*L2L)'($urandom);
    i_cfg_halt_on_err  = $urandom_range(1);
  endtask

  task automatic cycle();
    model_step();
    @(posedge i_clock);
    #1;
    compare();
  endtask

  task automatic step();
    rand_inputs();
    cycle();
  endtask

  task automatic pulse_start(input logic [3:0] g, input bit hoe);
    rand_inputs();
    i_start = 1'b1; i_cfg_gain_pow2 = g; i_cfg_halt_on_err = hoe;
    cycle();
  endtask

  task automatic pulse_stop();
    rand_inputs();
    i_stop = 1'b1;
    cycle();
  endtask

  task automatic pulse_clear();
    rand_inputs();
    i_clear_status = 1'b1;
    cycle();
  endtask

  task automatic run_until_in(input string tag, input int unsigned n);
    int unsigned k = 0;
    while (m_in_tot < n && k < 400) begin step(); k++; end
    check(tag, m_in_tot >= n, 1);
  endtask

  task automatic wait_state(input string tag, input int unsigned s);
    int unsigned k = 0;
    while (o_state != s && k < 400) begin step(); k++; end
    check(tag, o_state, s);
  endtask

  task automatic directed_knobs(input int unsigned v, input int unsigned o);
    vp = v; op = o; wild = 0; fpm = 0; sp = 0; stp = 0; clp = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt;
    bit prev_v;
    directed_knobs(0, 0);
    i_reset = 1'b0;
    rand_inputs();
    model_reset();
    #1 compare();
    @(posedge i_clock); #1;
    i_reset = 1'b1;

    // Continuous input, gain 3: alternate valid, two frames after 32 transfers.
    directed_knobs(100, 100);
    pulse_start(4'd3, 1'b0);
    prev_v = 1'b0;
    cnt = 0;
    while (m_in_tot < 32 && cnt < 200) begin
      step(); cnt++;
      check("A_gain", o_afb_gain_pow2, 3);
      check("A_valid_gap", prev_v && o_afb_valid, 0);
      prev_v = o_afb_valid;
    end
    check("A_in_frames", o_in_frames, 2);
    pulse_stop();
    wait_state("A_idle", 0);

    // Stop after 20 transfers: drain to 32, exit once output frames catch up.
    pulse_clear();
    pulse_start(4'($urandom), 1'b0);
    run_until_in("B_20", 20);
    pulse_stop();
    wait_state("B_idle", 0);
    check("B_in_frames", o_in_frames, 2);
    check("B_out_frames", o_out_frames, 2);
    check("B_no_tmo", o_status[5], 0);

    // Output stalled: drain timeout after exactly DTMO cycles.
    directed_knobs(100, 0);
    pulse_start(4'($urandom), 1'b0);
    run_until_in("C_20", 20);
    pulse_stop();
    wait_state("C_drain_out", 4);
    cnt = 0;
    while (o_state == 4 && cnt < 200) begin step(); cnt++; end
    check("C_tmo_cycles", cnt, DTMO);
    check("C_tmo_flag", o_status[5], 1);
    check("C_in_frames", o_in_frames, 2);

    // Fatal error with halt enabled.
    directed_knobs(60, 100);
    pulse_clear();
    pulse_start(4'($urandom), 1'b1);
    repeat (6) step();
    rand_inputs();
    i_afb_fft_overflow = 1'b1;
    cycle();
    check("D_halt", o_state, 5);
    check("D_ready", o_in_ready, 0);
    check("D_enable", o_afb_enable, 0);
    check("D_ovf", o_status[3], 1);
    repeat (2) step();
    pulse_clear();
    check("D_idle", o_state, 0);
    check("D_status", o_status, 0);

    // Non-fatal handling of errors with halt disabled.
    pulse_start(4'($urandom), 1'b0);
    repeat (6) step();
    rand_inputs();
    i_afb_fft_saturate = 4'b0100;
    i_afb_reorder_overflow = 1'b1;
    cycle();
    check("E_sat", o_status[4], 1);
    check("E_reorder", o_status[1], 1);
    check("E_run", o_state, 2);
    pulse_stop();
    wait_state("E_idle", 0);

    // Asynchronous reset mid-frame, then a fresh run counts from zero.
    pulse_start(4'($urandom), 1'b0);
    run_until_in("F_7", 7);
    #2 i_reset = 1'b0;
    #1;
    model_reset();
    check("F_rst_state", o_state, 0);
    check("F_rst_enable", o_afb_enable, 0);
    check("F_rst_frames", o_in_frames, 0);
    compare();
    #2 i_reset = 1'b1;
    pulse_start(4'($urandom), 1'b0);
    run_until_in("F_20", 20);
    check("F_in_frames", o_in_frames, 1);
    pulse_stop();
    wait_state("F_idle", 0);

    // Randomized mix of everything.
    vp = 70; op = 60; wild = 10; fpm = 8; sp = 10; stp = 3; clp = 2;
    repeat (3000) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/afb_ctrl.md
Name: afb_ctrl

Overview:
- Run controller for the analysis filter bank (polyphase filter + FFT).
- Sits between the upstream I/Q sample source and the AFB: gates and paces input samples to one per two clocks, latches PPF gain and FFT rounding per run, counts input/output frames.
- Sequences start/stop with a frame-aligned drain, collects AFB error flags into sticky status, optionally halts on fatal errors.

Parameters:
WIDTH, 32, I/Q sample width.
LOG2LEN, 10, log2 of FFT length; frame = 2^LOG2LEN samples.
FRAME_CNT_W, 16, width of the input and output frame counters.
DRAIN_TIMEOUT, 4096, max cycles in DRAIN_OUT before forced return to IDLE.

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous active-low reset
i_start  in  1  start pulse; honoured only in IDLE
i_stop  in  1  stop pulse; honoured in RUN and HALT
i_clear_status  in  1  clears sticky status and error counters
i_cfg_gain_pow2  in  4  PPF gain; latched on start
i_cfg_fft_rounding  in  2*LOG2LEN  FFT rounding; latched on start
i_cfg_halt_on_err  in  1  halt on fatal error; latched on start
i_in_inph, i_in_quad  in  WIDTH  upstream sample
i_in_valid  in  1  upstream valid
o_in_ready  out  1  upstream ready
o_afb_inph, o_afb_quad  out  WIDTH  sample to AFB
o_afb_valid  out  1  sample valid to AFB
o_afb_enable  out  1  AFB enable
o_afb_gain_pow2  out  4  latched gain
o_afb_fft_rounding  out  2*LOG2LEN  latched rounding
i_afb_out_valid, i_afb_out_ready  in  1  AFB output handshake (observed only)
i_afb_ppf_saturate, i_afb_reorder_overflow, i_afb_fft_underflow, i_afb_fft_overflow  in  1  AFB flags
i_afb_fft_saturate  in  LOG2LEN  per-stage FFT saturation
o_state  out  3  FSM state encoding
o_busy  out  1  state != IDLE
o_in_frames, o_out_frames  out  FRAME_CNT_W  completed frames this run
o_status  out  6  sticky: [0]ppf_sat [1]reorder_ovf [2]fft_unf [3]fft_ovf [4]fft_sat(OR of stages) [5]drain_timeout

Behaviour:
- Reset: all outputs 0; state IDLE; latched cfg 0; counters 0.
- States: IDLE(0), START(1), RUN(2), DRAIN_IN(3), DRAIN_OUT(4), HALT(5).
- IDLE: on i_start, latch cfg, clear frame counters and sample indices, go to START.
- START: lasts 1 cycle; o_afb_enable=1 from this cycle until IDLE/HALT; go to RUN.
- Pacing (RUN, DRAIN_IN): o_in_ready = state in {RUN,DRAIN_IN} && !gap.
- Transfer when i_in_valid && o_in_ready: data registered to o_afb_*; o_afb_valid=1 the next cycle for exactly one cycle.
- Gap flag is set for the cycle after each transfer, guaranteeing o_afb_valid is never high on consecutive cycles.
- Input index counts transfers mod 2^LOG2LEN; wrap to 0 increments o_in_frames (wraps mod 2^FRAME_CNT_W).
- Output index counts i_afb_out_valid && i_afb_out_ready cycles in any state except IDLE; wrap increments o_out_frames.
- RUN + i_stop: go to DRAIN_IN.
- DRAIN_IN: keep accepting until the input index is 0 (immediate if already 0, i.e. no partial frame), then go to DRAIN_OUT with o_in_ready=0.
- DRAIN_OUT: when o_out_frames == o_in_frames, go to IDLE. After DRAIN_TIMEOUT cycles without match, set status[5] and go to IDLE.
- IDLE entry: o_afb_enable=0; latched cfg and frame counters hold their values for readback.
- Sticky status: flags sampled every cycle while o_afb_enable=1.
- Set wins over i_clear_status in the same cycle.
- Fatal = reorder_overflow | fft_underflow | fft_overflow. If latched halt_on_err and fatal in START/RUN/DRAIN_*, go to HALT; fatal has priority over i_stop in the same cycle.
- HALT: o_in_ready=0, o_afb_enable=0, o_afb_valid=0. Leave to IDLE on i_stop or i_clear_status.
- i_start outside IDLE is ignored.
- Reset asserted mid-run returns immediately to reset values.

Optional Feature:
- Macro AFB_CTRL_ERR_CNT_EN.
- When defined: adds output o_err_cnt (4x16) with one saturating counter per fatal flag and ppf_saturate.
  - Each counter increments on every cycle its flag is high while enabled, saturating at 0xFFFF.
  - Cleared by reset and by i_clear_status; increment wins over clear.
- When undefined: port and logic absent; everything else is identical.

Decomposition:
- Package afb_ctrl_pkg holds:
  - the state enum (3-bit, values above);
  - status bit index constants;
  - the fatal-flag mask.
- One sub-module, afb_frame_counter: sample index mod 2^LOG2LEN plus frame counter with wrap pulse.
  - Instantiated twice, for input and output.

Test Plan:
- Continuous i_in_valid=1, LOG2LEN=4, gain=3, start: o_afb_valid toggles 1,0,1,0; after 32 transfers o_in_frames=2; o_afb_gain_pow2=3 throughout.
- i_stop after 20 input transfers (LOG2LEN=4): accepts 12 more; DRAIN_OUT exits to IDLE when o_out_frames=2 after 32 output handshakes.
- Same stop with output stalled (i_afb_out_ready=0), DRAIN_TIMEOUT=64: IDLE exactly 64 cycles after DRAIN_OUT entry; status[5]=1.
- halt_on_err=1, pulse fft_overflow in RUN: next cycle state=HALT, o_in_ready=0, enable=0, status[3]=1; i_clear_status -> IDLE, status=0.
- halt_on_err=0, pulse i_afb_fft_saturate=4'b0100 and reorder_overflow: status[4] and status[1] set; state stays RUN.
- Assert i_reset low mid-frame: all outputs 0 asynchronously; restart yields o_in_frames counting from 0.
